da_conv_serial: RTL and testbench
=================================

# da_conv_serial

Parametrised bit-serial distributed-arithmetic 3x3 convolution unit, the successor to the combinational fixed-width DA unit in the image-filter datapath. It accepts one 3x3 pixel window and nine signed coefficients through a valid/ready handshake. It processes one pixel bit-plane per cycle, MSB first, and returns the signed weighted sum, optionally clamped to the pixel range. It sits between the line-buffer window generator and the output pixel writer.

## Interface
- PIXEL_WIDTH, 3: unsigned pixel width in bits; also the number of SHIFT cycles.
- COEFF_WIDTH, 5: signed two's-complement coefficient width.
- OUT_WIDTH (localparam) = PIXEL_WIDTH+COEFF_WIDTH+4: signed result width.
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- pixel_row_0  input  3*PIXEL_WIDTH  window row 0; column c at bits [PIXEL_WIDTH*(c+1)-1 : PIXEL_WIDTH*c].
- pixel_row_1  input  3*PIXEL_WIDTH  window row 1, same packing.
- pixel_row_2  input  3*PIXEL_WIDTH  window row 2, same packing.
- coeffs  input  9*COEFF_WIDTH  k[r][c] at bits [COEFF_WIDTH*(3r+c) +: COEFF_WIDTH], signed.
- clamp_en  input  1  1: clamp the result to [0, 2^PIXEL_WIDTH-1].
- in_valid  input  1  window and coefficients valid.
- in_ready  output  1  unit can accept a window.
- output_data  output  OUT_WIDTH  result, signed, or zero-extended when clamped.
- out_valid  output  1  output_data valid.
- out_ready  input  1  downstream accepts the result.

## Operation
- FSM states: IDLE, SHIFT, DONE. in_ready = (state == IDLE). out_valid = (state == DONE).
- IDLE, in_valid=1: accept. Latch all pixels, coeffs and clamp_en. Clear acc (OUT_WIDTH signed). Set bit_cnt = PIXEL_WIDTH-1. Go to SHIFT.
- SHIFT, each cycle: psum = signed sum of k[r][c] over all taps where bit bit_cnt of p[r][c] is 1 (9-input sign-extended adder). Then acc <= (acc<<1) + psum.
  - bit_cnt==0: register the final value into output_data and go to DONE.
  - Otherwise: bit_cnt decrements.
- Result = sum of k[r][c]*p[r][c]. It is exact: OUT_WIDTH covers the worst case 9*(2^PIXEL_WIDTH-1)*2^(COEFF_WIDTH-1), so no overflow or wrap is possible.
- Clamp, when clamp_en is latched: negative -> 0; above 2^PIXEL_WIDTH-1 -> 2^PIXEL_WIDTH-1; otherwise unchanged. Not latched: raw signed sum.
- DONE: output_data and out_valid hold until out_ready=1, then go to IDLE. in_valid is ignored in DONE and SHIFT.
- Input changes after acceptance have no effect on the result in flight.
- Pixels are unsigned, so no sign-bit subtraction step is needed.

## Timing
- Reset (rst_n low, asynchronous): state=IDLE, in_ready=1, out_valid=0, output_data=0, acc=0, bit_cnt=0. Latched inputs are cleared.
- Reset mid-SHIFT or in DONE: the operation is abandoned and its result is never presented.
- Latency: out_valid rises PIXEL_WIDTH clock edges after the accept edge.
- Throughput: at best one result per PIXEL_WIDTH+2 cycles (accept, PIXEL_WIDTH shifts, DONE with out_ready=1, back to IDLE).
- out_valid and output_data are registered. in_ready and out_valid are decoded from the state register only, never from the inputs.
- Handshake fires on the rising edge when valid and ready are both 1. The result is consumed on the edge where out_valid and out_ready are both 1.

## Test plan
- Defaults, all coeffs=1, clamp_en=0, rows 9'b001001100 / 9'b001001001 / 9'b001001001 -> output_data=12, out_valid asserted exactly 3 edges after accept.
- Laplacian (center 8, others -1), center=7, others=0, clamp_en=0 -> 56; same window with clamp_en=1 -> 7.
- Laplacian, center=0, others=7, clamp_en=0 -> -56 (12'hFC8); clamp_en=1 -> 0. All pixels 7 -> 0.
- Extremes: all pixels 7 with all coeffs -16 -> -1008; with all coeffs 15 -> 945. No wrap.
- Backpressure: out_ready held low for 5 cycles in DONE while in_valid=1 and inputs toggle -> output_data stable, in_ready=0, no second accept. out_ready=1 -> IDLE next cycle.
- Assert rst_n low during the 2nd SHIFT cycle -> out_valid=0, output_data=0 immediately. After release, in_ready=1 and a fresh window computes correctly.

Source files
------------

// File: rtl/da_conv_serial.sv
// ============================================================================
// Module : da_conv_serial
// Brief  : Bit-serial distributed-arithmetic 3x3 convolution, MSB-first,
//          valid/ready handshake in and out, optional clamp to pixel range.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module da_conv_serial #(
  parameter int PIXEL_WIDTH = 3,
  parameter int COEFF_WIDTH = 5,
  localparam int OUT_WIDTH  = PIXEL_WIDTH + COEFF_WIDTH + 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [3*PIXEL_WIDTH-1:0]   pixel_row_0,
  input  logic [3*PIXEL_WIDTH-1:0]   pixel_row_1,
  input  logic [3*PIXEL_WIDTH-1:0]   pixel_row_2,
  input  logic [9*COEFF_WIDTH-1:0]   coeffs,
  input  logic                       clamp_en,
  input  logic                       in_valid,
  output logic                       in_ready,
  output logic [OUT_WIDTH-1:0]       output_data,
  output logic                       out_valid,
  input  logic                       out_ready
);

  localparam int BCW = (PIXEL_WIDTH > 1) ? $clog2(PIXEL_WIDTH) : 1;

  localparam logic [1:0] c_IDLE  = 2'd0;
  localparam logic [1:0] c_SHIFT = 2'd1;
  localparam logic [1:0] c_DONE  = 2'd2;

  localparam logic signed [OUT_WIDTH-1:0] c_PIX_MAX = OUT_WIDTH'((1 << PIXEL_WIDTH) - 1);

  logic [1:0]                    r_state;
  logic [9*PIXEL_WIDTH-1:0]      r_pix;
  logic [9*COEFF_WIDTH-1:0]      r_coeffs;
  logic                          r_clamp;
  logic signed [OUT_WIDTH-1:0]   r_acc;
  logic [BCW-1:0]                r_bit_cnt;
  logic [OUT_WIDTH-1:0]          r_output_data;

  logic [PIXEL_WIDTH-1:0]        w_tap;
  logic signed [COEFF_WIDTH-1:0] w_k;
  logic signed [OUT_WIDTH-1:0]   w_psum;
  logic signed [OUT_WIDTH-1:0]   w_acc_next;
  logic signed [OUT_WIDTH-1:0]   w_result;

  // Taps are packed row-major: tap t = 3*r + c, matching the coefficient order.
  always_comb begin
    w_psum = '0;
    w_tap  = '0;
    w_k    = '0;
    for (int t = 0; t < 9; t++) begin
      w_tap = r_pix[PIXEL_WIDTH*t +: PIXEL_WIDTH];
      w_k   = r_coeffs[COEFF_WIDTH*t +: COEFF_WIDTH];
      if (w_tap[r_bit_cnt]) begin
        w_psum = w_psum + OUT_WIDTH'(w_k);
      end
    end
  end

  assign w_acc_next = (r_acc <<< 1) + w_psum;

  always_comb begin
    w_result = w_acc_next;
    if (r_clamp) begin
      if (w_acc_next < 0) begin
        w_result = '0;
      end else if (w_acc_next > c_PIX_MAX) begin
        w_result = c_PIX_MAX;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= c_IDLE;
      r_pix         <= '0;
      r_coeffs      <= '0;
      r_clamp       <= 1'b0;
      r_acc         <= '0;
      r_bit_cnt     <= '0;
      r_output_data <= '0;
    end else begin
      case (r_state)
        c_IDLE: begin
          if (in_valid) begin
            r_pix     <= {pixel_row_2, pixel_row_1, pixel_row_0};
            r_coeffs  <= coeffs;
            r_clamp   <= clamp_en;
            r_acc     <= '0;
            r_bit_cnt <= BCW'(PIXEL_WIDTH - 1);
            r_state   <= c_SHIFT;
          end
        end
        c_SHIFT: begin
          r_acc <= w_acc_next;
          if (r_bit_cnt == '0) begin
            r_output_data <= w_result;
            r_state       <= c_DONE;
          end else begin
            r_bit_cnt <= r_bit_cnt - 1'b1;
          end
        end
        c_DONE: begin
          if (out_ready) begin
            r_state <= c_IDLE;
          end
        end
        default: r_state <= c_IDLE;
      endcase
    end
  end

  assign in_ready    = (r_state == c_IDLE);
  assign out_valid   = (r_state == c_DONE);
  assign output_data = r_output_data;

endmodule

`default_nettype wire

// File: tb/tb_da_conv_serial.sv
// ============================================================================
// Module : tb_da_conv_serial
// Brief  : Directed and random checks of da_conv_serial against a
//          multiply-accumulate reference model.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_da_conv_serial;

  localparam int PW = 3;
  localparam int CW = 5;
  localparam int OW = PW + CW + 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [3*PW-1:0] pixel_row_0 = '0;
  logic [3*PW-1:0] pixel_row_1 = '0;
  logic [3*PW-1:0] pixel_row_2 = '0;
  logic [9*CW-1:0] coeffs = '0;
  logic          clamp_en = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [OW-1:0] output_data;
  logic          out_valid;
  logic          out_ready = 1'b0;

  int total = 0;
  int bad   = 0;

  da_conv_serial #(.PIXEL_WIDTH(PW), .COEFF_WIDTH(CW)) dut (
    .clk(clk), .rst_n(rst_n),
    .pixel_row_0(pixel_row_0), .pixel_row_1(pixel_row_1), .pixel_row_2(pixel_row_2),
    .coeffs(coeffs), .clamp_en(clamp_en),
    .in_valid(in_valid), .in_ready(in_ready),
    .output_data(output_data), .out_valid(out_valid), .out_ready(out_ready)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Reference: plain sum of products over the 3x3 window, then optional clamp.
  function automatic int model(input logic [9*PW-1:0] pix, input logic [9*CW-1:0] k, input bit cl);
    int sum;
    int p;
    int kv;
    sum = 0;
    for (int t = 0; t < 9; t++) begin
      p   = int'(pix[PW*t +: PW]);
      kv  = int'($signed(k[CW*t +: CW]));
      sum = sum + p * kv;
    end
    if (cl) begin
      if (sum < 0) sum = 0;
      else if (sum > (1 << PW) - 1) sum = (1 << PW) - 1;
    end
    return sum;
  endfunction

  function automatic logic [9*CW-1:0] all_k(input int v);
    logic [9*CW-1:0] k;
    for (int t = 0; t < 9; t++) k[CW*t +: CW] = CW'(v);
    return k;
  endfunction

  function automatic logic [9*CW-1:0] lap_k();
    logic [9*CW-1:0] k;
    k = all_k(-1);
    k[CW*4 +: CW] = CW'(8);
    return k;
  endfunction

  function automatic logic [9*PW-1:0] all_p(input int v);
    logic [9*PW-1:0] p;
    for (int t = 0; t < 9; t++) p[PW*t +: PW] = PW'(v);
    return p;
  endfunction

  function automatic int out_s();
    return int'($signed(output_data));
  endfunction

  task automatic drive(input logic [9*PW-1:0] pix, input logic [9*CW-1:0] k, input bit cl);
    pixel_row_0 = pix[0 +: 3*PW];
    pixel_row_1 = pix[3*PW +: 3*PW];
    pixel_row_2 = pix[6*PW +: 3*PW];
    coeffs      = k;
    clamp_en    = cl;
  endtask

  // Accept one window, scramble inputs, measure latency, check and consume.
  task automatic run_window(input string tag, input logic [9*PW-1:0] pix,
                            input logic [9*CW-1:0] k, input bit cl, input int exp);
    int n;
    n = 0;
    while (!in_ready && n < 20) begin @(posedge clk); #1; n++; end
    check({tag, "_in_ready"}, int'(in_ready), 1);
    drive(pix, k, cl);
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    drive(9*PW'($urandom), {$urandom, $urandom}, 1'($urandom));
    n = 0;
    while (!out_valid && n < 20) begin @(posedge clk); #1; n++; end
    check({tag, "_latency"}, n, PW);
    check({tag, "_value"}, out_s(), exp);
    repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
    check({tag, "_held"}, out_s(), exp);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check({tag, "_released"}, int'(out_valid), 0);
  endtask

  initial begin
    logic [9*PW-1:0] pix;
    logic [9*CW-1:0] k;
    bit              cl;
    int              held;

    #12;
    check("reset_in_ready", int'(in_ready), 1);
    check("reset_out_valid", int'(out_valid), 0);
    check("reset_data", int'(output_data), 0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;

    run_window("ones", {9'b001001001, 9'b001001001, 9'b001001100}, all_k(1), 1'b0, 12);
    pix = 27'd7 << (PW*4);
    run_window("lap_c7", pix, lap_k(), 1'b0, 56);
    run_window("lap_c7_cl", pix, lap_k(), 1'b1, 7);
    pix = all_p(7);
    pix[PW*4 +: PW] = '0;
    run_window("lap_o7", pix, lap_k(), 1'b0, -56);
    check("lap_o7_raw", int'(output_data), 'hFC8);
    run_window("lap_o7_cl", pix, lap_k(), 1'b1, 0);
    run_window("lap_all7", all_p(7), lap_k(), 1'b0, 0);
    run_window("min_ext", all_p(7), all_k(-16), 1'b0, -1008);
    run_window("max_ext", all_p(7), all_k(15), 1'b0, 945);

    // Backpressure: hold the result while the upstream keeps offering windows.
    drive(all_p(5), all_k(3), 1'b0);
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b1;
    repeat (PW) begin @(posedge clk); #1; end
    check("bp_valid", int'(out_valid), 1);
    check("bp_value", out_s(), model(all_p(5), all_k(3), 1'b0));
    held = out_s();
    for (int i = 0; i < 5; i++) begin
      drive(27'($urandom), {$urandom, $urandom}, 1'($urandom));
      @(posedge clk); #1;
      check("bp_stable", out_s(), held);
      check("bp_no_accept", int'(in_ready), 0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("bp_idle", int'(in_ready), 1);

    // Reset during the second SHIFT cycle abandons the operation.
    drive(all_p(7), all_k(15), 1'b0);
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    check("rst_out_valid", int'(out_valid), 0);
    check("rst_data", int'(output_data), 0);
    check("rst_in_ready", int'(in_ready), 1);
    @(negedge clk); rst_n = 1'b1;
    repeat (4) begin @(posedge clk); #1; end
    check("rst_no_result", int'(out_valid), 0);
    run_window("after_rst", all_p(3), all_k(-2), 1'b0, -54);

    for (int i = 0; i < 40; i++) begin
      pix = 27'($urandom);
      k   = {$urandom, $urandom};
      cl  = 1'($urandom);
      run_window($sformatf("rand%0d", i), pix, k, cl, model(pix, k, cl));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    bad++;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire
